// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch/execute/BHT signal bundle for the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int table_width = 3,
    parameter int queue_depth = 4
);
    logic                   F_Valid;
    logic [31:0]            F_PC;
    logic                   F_PredictTaken;
    logic                   F_Ready;
    logic                   EX_Valid;
    logic                   EX_Taken;
    logic [31:0]            EX_Target;
    logic [table_width-1:0] JB_PC_Slice;
    logic                   JB_BranchTaken;
    logic                   JB_AttemptBranch;
    logic                   Flush;
    logic [31:0]            Redirect_PC;
    logic [15:0]            Branch_Count;
    logic [15:0]            Mispredict_Count;
    logic                   Err_Underflow;

    modport master (
        output F_Valid, F_PC, F_PredictTaken, EX_Valid, EX_Taken, EX_Target,
        input  F_Ready, JB_PC_Slice, JB_BranchTaken, JB_AttemptBranch, Flush,
               Redirect_PC, Branch_Count, Mispredict_Count, Err_Underflow
    );

    modport slave (
        input  F_Valid, F_PC, F_PredictTaken, EX_Valid, EX_Taken, EX_Target,
        output F_Ready, JB_PC_Slice, JB_BranchTaken, JB_AttemptBranch, Flush,
               Redirect_PC, Branch_Count, Mispredict_Count, Err_Underflow
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order predicted-branch queue with BHT update and mispredict flush
// Execute always resolves the oldest in-flight branch; a mispredict empties the queue and stalls fetch one cycle.
module branch_resolve_unit #(
    parameter int table_width = 3,
    parameter int queue_depth = 4
) (
    input  logic                clk,
    input  logic                rst,
    branch_resolve_unit_if.slave bus
);
    localparam int ptr_w = (queue_depth > 1) ? $clog2(queue_depth) : 1;
    localparam int cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] depth_c = cnt_w'(queue_depth);

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [cnt_w-1:0]       count_q, count_d;
    logic [ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
    logic [31:0]            mem_pc_q   [queue_depth];
    logic [31:0]            mem_pc_d   [queue_depth];
    logic                   mem_pred_q [queue_depth];
    logic                   mem_pred_d [queue_depth];
    logic                   attempt_q, attempt_d;
    logic                   taken_q, taken_d;
    logic [table_width-1:0] slice_q, slice_d;
    logic                   flush_q, flush_d;
    logic [31:0]            redirect_q, redirect_d;
    logic [15:0]            branch_cnt_q, branch_cnt_d;
    logic [15:0]            mispred_cnt_q, mispred_cnt_d;
    logic                   err_q, err_d;

    logic        run;
    logic        f_ready;
    logic        push;
    logic        pop;
    logic        mispredict;
    logic [31:0] head_pc;
    logic        head_pred;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign run        = (state_q == RUN);
    assign f_ready    = run && (count_q < depth_c);
    assign push       = bus.F_Valid && f_ready;
    assign pop        = run && bus.EX_Valid && (count_q != '0);
    assign head_pc    = mem_pc_q[rd_ptr_q];
    assign head_pred  = mem_pred_q[rd_ptr_q];
    assign mispredict = pop && (bus.EX_Taken != head_pred);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        mem_pc_d      = mem_pc_q;
        mem_pred_d    = mem_pred_q;
        attempt_d     = 1'b0;
        flush_d       = 1'b0;
        taken_d       = taken_q;
        slice_d       = slice_q;
        redirect_d    = redirect_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        err_d         = err_q;

        if (state_q == RECOVER) begin
            state_d = RUN;
        end

        if (run && bus.EX_Valid && (count_q == '0)) begin
            err_d = 1'b1;
        end

        if (pop) begin
            attempt_d = 1'b1;
            slice_d   = head_pc[table_width+1:2];
            taken_d   = bus.EX_Taken;
            if (branch_cnt_q != 16'hFFFF) begin
                branch_cnt_d = branch_cnt_q + 16'd1;
            end
        end

        if (mispredict) begin
            // Everything younger than the mispredicted branch is wrong-path, including this cycle's push.
            flush_d    = 1'b1;
            redirect_d = bus.EX_Taken ? bus.EX_Target : head_pc + 32'd4;
            if (mispred_cnt_q != 16'hFFFF) begin
                mispred_cnt_d = mispred_cnt_q + 16'd1;
            end
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = RECOVER;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]   = bus.F_PC;
                mem_pred_d[wr_ptr_q] = bus.F_PredictTaken;
                wr_ptr_d             = wr_ptr_q + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_w'(1);
            end
            count_d = count_q + cnt_w'(push) - cnt_w'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            attempt_q     <= 1'b0;
            taken_q       <= 1'b0;
            slice_q       <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            attempt_q     <= attempt_d;
            taken_q       <= taken_d;
            slice_q       <= slice_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            err_q         <= err_d;
        end
    end

    // Entry storage is only read behind a valid count, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_pc_q   <= mem_pc_d;
        mem_pred_q <= mem_pred_d;
    end

    assign bus.F_Ready          = f_ready;
    assign bus.JB_AttemptBranch = attempt_q;
    assign bus.JB_BranchTaken   = taken_q;
    assign bus.JB_PC_Slice      = slice_q;
    assign bus.Flush            = flush_q;
    assign bus.Redirect_PC      = redirect_q;
    assign bus.Branch_Count     = branch_cnt_q;
    assign bus.Mispredict_Count = mispred_cnt_q;
    assign bus.Err_Underflow    = err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.table_width(3), .queue_depth(4)) bus();
    branch_resolve_unit #(.table_width(3), .queue_depth(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0]  slice;
        logic        taken;
        logic        flush;
        logic [31:0] redirect;
    } upd_t;

    upd_t exp_q[$];
    upd_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    task automatic expect_upd(input logic [2:0] slice, input logic taken, input logic flush,
                              input logic [31:0] redirect);
        upd_t e;
        e.slice = slice; e.taken = taken; e.flush = flush; e.redirect = redirect;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic fv, input logic [31:0] pc, input logic pred,
                       input logic ev, input logic tk, input logic [31:0] tgt);
        bus.F_Valid = fv; bus.F_PC = pc; bus.F_PredictTaken = pred;
        bus.EX_Valid = ev; bus.EX_Taken = tk; bus.EX_Target = tgt;
        @(posedge clk);
        #1;
        bus.F_Valid = 1'b0;
        bus.EX_Valid = 1'b0;
    endtask

    // Monitor: every update pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.JB_AttemptBranch) begin
                check("update_was_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("jb_slice", 32'(bus.JB_PC_Slice), 32'(mon_e.slice));
                    check("jb_taken", 32'(bus.JB_BranchTaken), 32'(mon_e.taken));
                    check("flush", 32'(bus.Flush), 32'(mon_e.flush));
                    if (mon_e.flush) check("redirect_pc", bus.Redirect_PC, mon_e.redirect);
                end
            end else begin
                check("flush_idle", 32'(bus.Flush), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.F_Valid = 0; bus.F_PC = 0; bus.F_PredictTaken = 0;
        bus.EX_Valid = 0; bus.EX_Taken = 0; bus.EX_Target = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_f_ready", 32'(bus.F_Ready), 32'd1);
        check("rst_attempt", 32'(bus.JB_AttemptBranch), 32'd0);
        check("rst_taken", 32'(bus.JB_BranchTaken), 32'd0);
        check("rst_slice", 32'(bus.JB_PC_Slice), 32'd0);
        check("rst_flush", 32'(bus.Flush), 32'd0);
        check("rst_redirect", bus.Redirect_PC, 32'd0);
        check("rst_bcount", 32'(bus.Branch_Count), 32'd0);
        check("rst_mcount", 32'(bus.Mispredict_Count), 32'd0);
        check("rst_err", 32'(bus.Err_Underflow), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Correct taken prediction
        cyc(1, 32'h10, 1, 0, 0, 0);
        expect_upd(3'b100, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'hDEAD_0000);
        check("c1_bcount", 32'(bus.Branch_Count), 32'd1);
        check("c1_mcount", 32'(bus.Mispredict_Count), 32'd0);

        // Not-taken mispredict
        cyc(1, 32'h100, 1, 0, 0, 0);
        expect_upd(3'b000, 0, 1, 32'h104);
        cyc(0, 0, 0, 1, 0, 32'h5555_0000);
        check("c2_f_ready_recover", 32'(bus.F_Ready), 32'd0);
        check("c2_mcount", 32'(bus.Mispredict_Count), 32'd1);
        check("c2_bcount", 32'(bus.Branch_Count), 32'd2);
        cyc(0, 0, 0, 0, 0, 0);
        check("c2_f_ready_run", 32'(bus.F_Ready), 32'd1);

        // Taken mispredict with younger entries and a same-cycle push
        cyc(1, 32'h200, 0, 0, 0, 0);
        cyc(1, 32'h204, 1, 0, 0, 0);
        cyc(1, 32'h208, 1, 0, 0, 0);
        expect_upd(3'b000, 1, 1, 32'h2000);
        cyc(1, 32'h300, 1, 1, 1, 32'h2000);
        check("c3_f_ready_recover", 32'(bus.F_Ready), 32'd0);
        check("c3_mcount", 32'(bus.Mispredict_Count), 32'd2);
        cyc(0, 0, 0, 0, 0, 0);
        check("c3_f_ready_run", 32'(bus.F_Ready), 32'd1);
        cyc(1, 32'h4C, 1, 0, 0, 0);
        expect_upd(3'b011, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        check("c3_bcount", 32'(bus.Branch_Count), 32'd4);
        check("c3_err", 32'(bus.Err_Underflow), 32'd0);

        // Fill, dropped extra push, then steady push/pop across the pointer wrap
        for (int k = 1; k <= 4; k++) cyc(1, 32'(4 * k), 1, 0, 0, 0);
        check("c4_full_f_ready", 32'(bus.F_Ready), 32'd0);
        cyc(1, 32'h3C, 0, 0, 0, 0);
        check("c4_full_still", 32'(bus.F_Ready), 32'd0);
        expect_upd(3'd1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            check("c4_wrap_f_ready", 32'(bus.F_Ready), 32'd1);
            expect_upd(3'(2 + i), 1, 0, 0);
            cyc(1, 32'(4 * (5 + i)), 1, 1, 1, 0);
        end
        for (int k = 8; k <= 10; k++) begin
            expect_upd(3'(k), 1, 0, 0);
            cyc(0, 0, 0, 1, 1, 0);
        end
        check("c4_bcount", 32'(bus.Branch_Count), 32'd14);
        check("c4_mcount", 32'(bus.Mispredict_Count), 32'd2);
        check("c4_f_ready", 32'(bus.F_Ready), 32'd1);

        // Underflow with the queue empty
        cyc(0, 0, 0, 1, 1, 0);
        check("c5_err_set", 32'(bus.Err_Underflow), 32'd1);
        check("c5_bcount", 32'(bus.Branch_Count), 32'd14);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        check("c5_err_sticky", 32'(bus.Err_Underflow), 32'd1);

        // Reset while Flush is high
        cyc(1, 32'h80, 0, 0, 0, 0);
        expect_upd(3'b000, 1, 1, 32'h1234);
        cyc(0, 0, 0, 1, 1, 32'h1234);
        @(negedge clk);
        #1;
        check("c6_flush_high", 32'(bus.Flush), 32'd1);
        rst = 1'b1;
        #1;
        check("c6_rst_f_ready", 32'(bus.F_Ready), 32'd1);
        check("c6_rst_attempt", 32'(bus.JB_AttemptBranch), 32'd0);
        check("c6_rst_taken", 32'(bus.JB_BranchTaken), 32'd0);
        check("c6_rst_slice", 32'(bus.JB_PC_Slice), 32'd0);
        check("c6_rst_flush", 32'(bus.Flush), 32'd0);
        check("c6_rst_redirect", bus.Redirect_PC, 32'd0);
        check("c6_rst_bcount", 32'(bus.Branch_Count), 32'd0);
        check("c6_rst_mcount", 32'(bus.Mispredict_Count), 32'd0);
        check("c6_rst_err", 32'(bus.Err_Underflow), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("c6_f_ready_after", 32'(bus.F_Ready), 32'd1);
        cyc(1, 32'h4C, 1, 0, 0, 0);
        expect_upd(3'b011, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        check("c6_bcount", 32'(bus.Branch_Count), 32'd1);

        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
